// File: rtl/ohc_pkg.sv
// Shared one-hot residue helpers for modulo-M arithmetic (M up to OHC_MAX_M).
// Vectors are carried at full width; callers pass the modulus and slice to M bits.
package ohc_pkg;

    localparam int OHC_MAX_M = 64;
    localparam int OHC_MAX_W = 6;

    typedef logic [OHC_MAX_M-1:0] ohc_vec_t;
    typedef logic [OHC_MAX_W-1:0] ohc_bin_t;

    // Residues at or above m have no bit to map to, so they encode as all-zeros.
    function automatic ohc_vec_t bin2ohc(input ohc_bin_t r, input int m);
        ohc_vec_t v;
        v = '0;
        for (int i = 0; i < OHC_MAX_M; i++) begin
            if (i < m && r == ohc_bin_t'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic ohc_bin_t ohc2bin(input ohc_vec_t v);
        ohc_bin_t r;
        r = '0;
        for (int i = 0; i < OHC_MAX_M; i++) begin
            if (v[i]) r = r | ohc_bin_t'(i);
        end
        return r;
    endfunction

    // Rotate v left by the position of the single set bit in sh, wrapping at m.
    function automatic ohc_vec_t ohc_rotate_mod(input ohc_vec_t v, input ohc_vec_t sh, input int m);
        ohc_vec_t r;
        r = '0;
        for (int s = 0; s < OHC_MAX_M; s++) begin
            for (int i = 0; i < OHC_MAX_M; i++) begin
                if (s < m && i < m && sh[s] && v[i]) r[(i + s) % m] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ohc_mod_adder_pipe_rotate.sv
// Combinational modulo-M rotator: one-hot vec rotated left by one-hot shift_ohc.
module ohc_rotate
    import ohc_pkg::*;
#(
    parameter int M = 11
)(
    input  logic [M-1:0] vec,
    input  logic [M-1:0] shift_ohc,
    output logic [M-1:0] rotated
);

    ohc_vec_t vec_x;
    ohc_vec_t sh_x;
    ohc_vec_t rot_x;
    logic     unused_rot;

    always_comb begin
        vec_x         = '0;
        vec_x[M-1:0]  = vec;
        sh_x          = '0;
        sh_x[M-1:0]   = shift_ohc;
        rot_x         = ohc_rotate_mod(vec_x, sh_x, M);
    end

    assign rotated    = rot_x[M-1:0];
    assign unused_rot = ^rot_x;

endmodule

// File: rtl/ohc_mod_adder_pipe.sv
// Two-stage modulo-M adder on one-hot residues with valid/ready handshakes.
// Optional OHC_RANGE_CHECK_EN adds out_err, flagging operands >= M.
module ohc_mod_adder_pipe
    import ohc_pkg::*;
#(
    parameter  int M = 11,
    localparam int W = $clog2(M)
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_ohc,
    output logic [W-1:0] out_bin
`ifdef OHC_RANGE_CHECK_EN
    ,
    output logic         out_err
`endif
);

    logic         s1_adv;
    logic         s2_adv;
    logic         vld_p1;
    logic         vld_p2;
    ohc_vec_t     a_full;
    ohc_vec_t     b_full;
    ohc_vec_t     rot_full;
    ohc_bin_t     bin_full;
    logic [M-1:0] ohc_a_p0;
    logic [M-1:0] ohc_b_p0;
    logic [M-1:0] ohc_a_p1;
    logic [M-1:0] ohc_b_p1;
    logic [M-1:0] rot_p1;
    logic [M-1:0] ohc_p2;
    logic [W-1:0] bin_p2;
    logic         unused_bits;

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    // Idle cycles load zeros so data registers stay clear whenever their valid is low.
    always_comb begin
        a_full   = bin2ohc(ohc_bin_t'(in_a), M);
        b_full   = bin2ohc(ohc_bin_t'(in_b), M);
        ohc_a_p0 = in_valid ? a_full[M-1:0] : '0;
        ohc_b_p0 = in_valid ? b_full[M-1:0] : '0;
    end

    // S1: operand one-hots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            ohc_a_p1 <= '0;
            ohc_b_p1 <= '0;
        end else if (s1_adv) begin
            vld_p1   <= in_valid;
            ohc_a_p1 <= ohc_a_p0;
            ohc_b_p1 <= ohc_b_p0;
        end
    end

    ohc_rotate #(.M(M)) u_rotate (
        .vec       (ohc_a_p1),
        .shift_ohc (ohc_b_p1),
        .rotated   (rot_p1)
    );

    always_comb begin
        rot_full        = '0;
        rot_full[M-1:0] = rot_p1;
        bin_full        = ohc2bin(rot_full);
    end

    // S2: rotated sum and its binary form
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            ohc_p2 <= '0;
            bin_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            ohc_p2 <= vld_p1 ? rot_p1 : '0;
            bin_p2 <= vld_p1 ? bin_full[W-1:0] : '0;
        end
    end

    assign out_valid   = vld_p2;
    assign out_ohc     = ohc_p2;
    assign out_bin     = bin_p2;
    assign unused_bits = ^{a_full, b_full, bin_full};

`ifdef OHC_RANGE_CHECK_EN
    logic err_p0;
    logic err_p1;
    logic err_p2;

    // An out-of-range operand is exactly one whose one-hot came out empty.
    assign err_p0 = in_valid && (~|a_full[M-1:0] || ~|b_full[M-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p1 <= 1'b0;
            err_p2 <= 1'b0;
        end else begin
            if (s1_adv) err_p1 <= err_p0;
            if (s2_adv) err_p2 <= vld_p1 && err_p1;
        end
    end

    assign out_err = err_p2;
`endif

endmodule
